aliens_bus_initiator: RTL and testbench

Synthesizable CPU-side bus-cycle initiator for the Aliens memory map. It accepts single-byte read/write requests on a valid/ready port, drives the address strobe and upper address lines into the address-decode PAL, and owns the BK4 and WOCO control bits that the PAL consumes. It samples the PAL's active-low select outputs during the strobe and returns them as a response. It also serves as the stimulus engine for the decode-PAL simulation bench.

---
 rtl/aliens_bus_pkg.sv | 28 ++
 rtl/aliens_sel_checker.sv | 24 ++
 rtl/aliens_bus_initiator.sv | 174 +++++++++++++++++
 tb/tb_aliens_bus_initiator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aliens_bus_pkg.sv
// Shared types and constants for the Aliens CPU-side bus-cycle initiator.
// Holds the bus FSM state enum, select bit indices and control-register layout.
package aliens_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RECOVER
    } bus_state_e;

    // Bit positions inside rsp_sel, {PROG, BANK, WORK, IO, D17}
    localparam int SEL_PROG = 4;
    localparam int SEL_BANK = 3;
    localparam int SEL_WORK = 2;
    localparam int SEL_IO   = 1;
    localparam int SEL_D17  = 0;

    localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'h5F88;

    localparam int BK4_BIT  = 4;
    localparam int WOCO_BIT = 5;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/aliens_sel_checker.sv
// Combinational select-consistency check for the decode PAL outputs.
// Only built when ALIENS_BUS_SELCHK_EN is defined.
`ifdef ALIENS_BUS_SELCHK_EN
module aliens_sel_checker
    import aliens_bus_pkg::*;
(
    input  logic prog_act,
    input  logic bank_act,
    input  logic work_act,
    input  logic d21_19_n,
    output logic err
);

    logic any_mem;
    logic multi_mem;

    assign any_mem   = prog_act | bank_act | work_act;
    assign multi_mem = (prog_act & bank_act) | (prog_act & work_act) | (bank_act & work_act);

    // D21_19 is the PAL's own "some memory select is active" output
    assign err = multi_mem | ((~d21_19_n) != any_mem);

endmodule
`endif

// File: rtl/aliens_bus_initiator.sv
// Bus-cycle initiator driving AS/MA/RW/DOUT into the Aliens decode PAL and owning BK4/WOCO.
// Define ALIENS_BUS_SELCHK_EN to enable the select-consistency error on rsp_err.
module aliens_bus_initiator
    import aliens_bus_pkg::*;
#(
    parameter int          AS_LOW_CYCLES = 4,
    parameter int          SETUP_CYCLES  = 1,
    parameter logic [15:0] CTRL_ADDR     = CTRL_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [4:0]  rsp_sel,
    output logic        rsp_err,
    output logic        AS,
    output logic [15:0] MA,
    output logic        RW,
    output logic [7:0]  DOUT,
    output logic        BK4,
    output logic        WOCO,
    input  logic        WORK,
    input  logic        BANK,
    input  logic        PROG,
    input  logic        D21_15,
    input  logic        D21_17,
    input  logic        D21_19
);

    localparam int CNT_W = cnt_width(AS_LOW_CYCLES, SETUP_CYCLES);
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(AS_LOW_CYCLES - 1);

    bus_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             as_q, as_d;
    logic             ready_q, ready_d;
    logic [15:0]      ma_q, ma_d;
    logic             rw_q, rw_d;
    logic [7:0]       dout_q, dout_d;
    logic             bk4_q, bk4_d;
    logic             woco_q, woco_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [4:0]       rsp_sel_q, rsp_sel_d;
    logic             rsp_err_q, rsp_err_d;

    logic [4:0]       sel_live;
    logic             sel_err_live;

    assign sel_live[SEL_PROG] = ~PROG;
    assign sel_live[SEL_BANK] = ~BANK;
    assign sel_live[SEL_WORK] = ~WORK;
    assign sel_live[SEL_IO]   = ~D21_15;
    assign sel_live[SEL_D17]  = ~D21_17;

`ifdef ALIENS_BUS_SELCHK_EN
    aliens_sel_checker u_sel_checker (
        .prog_act (sel_live[SEL_PROG]),
        .bank_act (sel_live[SEL_BANK]),
        .work_act (sel_live[SEL_WORK]),
        .d21_19_n (D21_19),
        .err      (sel_err_live)
    );
`else
    logic unused_d21_19;
    assign unused_d21_19 = D21_19;
    assign sel_err_live  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ma_d        = ma_q;
        rw_d        = rw_q;
        dout_d      = dout_q;
        bk4_d       = bk4_q;
        woco_d      = woco_q;
        rsp_valid_d = 1'b0;
        rsp_sel_d   = rsp_sel_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    ma_d    = req_addr;
                    rw_d    = ~req_we;
                    dout_d  = req_wdata;
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = STROBE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Selects have settled for the whole strobe; BK4/WOCO change only after this sample
                    rsp_sel_d   = sel_live;
                    rsp_err_d   = sel_err_live;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_RECOVER;
                    if (!rw_q && (ma_q == CTRL_ADDR)) begin
                        bk4_d  = dout_q[BK4_BIT];
                        woco_d = dout_q[WOCO_BIT];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RECOVER: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        as_d    = (state_d != ST_STROBE);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            as_q        <= 1'b1;
            ready_q     <= 1'b1;
            ma_q        <= '0;
            rw_q        <= 1'b1;
            dout_q      <= '0;
            bk4_q       <= 1'b0;
            woco_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sel_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            as_q        <= as_d;
            ready_q     <= ready_d;
            ma_q        <= ma_d;
            rw_q        <= rw_d;
            dout_q      <= dout_d;
            bk4_q       <= bk4_d;
            woco_q      <= woco_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_err   = rsp_err_q;
    assign AS        = as_q;
    assign MA        = ma_q;
    assign RW        = rw_q;
    assign DOUT      = dout_q;
    assign BK4       = bk4_q;
    assign WOCO      = woco_q;

endmodule

// File: tb/tb_aliens_bus_initiator.sv
// Bench for aliens_bus_initiator: decode-PAL model, per-cycle model comparison and directed transactions.
// Expectations follow ALIENS_BUS_SELCHK_EN when it is defined for the build.
module tb_aliens_bus_initiator;

    localparam int          S    = 1;
    localparam int          L    = 4;
    localparam logic [15:0] CTRL = 16'h5F88;
`ifdef ALIENS_BUS_SELCHK_EN
    localparam logic SELCHK = 1'b1;
`else
    localparam logic SELCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, AS, RW, BK4, WOCO;
    logic [4:0]  rsp_sel;
    logic [15:0] MA;
    logic [7:0]  DOUT;
    logic        WORK, BANK, PROG, D21_15, D21_17, D21_19;
    logic        force_d19 = 1'b0;
    logic        mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aliens_bus_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
        .AS(AS), .MA(MA), .RW(RW), .DOUT(DOUT), .BK4(BK4), .WOCO(WOCO),
        .WORK(WORK), .BANK(BANK), .PROG(PROG),
        .D21_15(D21_15), .D21_17(D21_17), .D21_19(D21_19)
    );

    // Memory map as the PAL decodes it, result is active-high {PROG, BANK, WORK, IO, D17}
    function automatic logic [4:0] decode(input logic [15:0] a, input logic bk4, input logic woco);
        logic [4:0] s;
        s = '0;
        if (a >= 16'h8000) s[4] = 1'b1;
        else if (a >= 16'h4000) begin
            s[0] = 1'b1;
            if (a >= 16'h5C00 && a < 16'h6000) s[1] = 1'b1;
        end
        else if (a >= 16'h2000) begin
            if (bk4) s[4] = 1'b1;
            else     s[3] = 1'b1;
        end
        else begin
            if (woco) s[0] = 1'b1;
            else      s[2] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic model_err(input logic [4:0] s, input logic frc);
        int   n;
        logic d19_pin;
        n       = int'(s[4]) + int'(s[3]) + int'(s[2]);
        d19_pin = frc ? 1'b1 : ~(|s[4:2]);
        return SELCHK & ((n > 1) || ((~d19_pin) != (|s[4:2])));
    endfunction

    logic [4:0] pal_act;
    assign pal_act = AS ? 5'b0 : decode(MA, BK4, WOCO);
    assign PROG    = ~pal_act[4];
    assign BANK    = ~pal_act[3];
    assign WORK    = ~pal_act[2];
    assign D21_15  = ~pal_act[1];
    assign D21_17  = ~pal_act[0];
    assign D21_19  = force_d19 ? 1'b1 : ~(|pal_act[4:2]);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: cycle index k since acceptance (k=1 first cycle after the accepting edge)
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic [15:0] m_ma = '0;
    logic        m_rw = 1'b1;
    logic [7:0]  m_dout = '0;
    logic        m_bk4 = 1'b0, m_woco = 1'b0, m_err = 1'b0;
    logic [4:0]  m_sel = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_k <= 0; m_ma <= '0; m_rw <= 1'b1; m_dout <= '0;
            m_bk4 <= 1'b0; m_woco <= 1'b0; m_sel <= '0; m_err <= 1'b0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1; m_k <= 1;
                m_ma <= req_addr; m_rw <= ~req_we; m_dout <= req_wdata;
            end
        end else begin
            if (m_k == S + L) begin
                m_sel <= decode(m_ma, m_bk4, m_woco);
                m_err <= model_err(decode(m_ma, m_bk4, m_woco), force_d19);
                if (!m_rw && m_ma == CTRL) begin
                    m_bk4  <= m_dout[4];
                    m_woco <= m_dout[5];
                end
            end
            if (m_k == S + L + 1) begin
                m_busy <= 1'b0; m_k <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("cyc_as",    32'(AS),        32'(!(m_busy && m_k >= S + 1 && m_k <= S + L)));
            chk("cyc_ready", 32'(req_ready), 32'(!m_busy));
            chk("cyc_rv",    32'(rsp_valid), 32'(m_busy && m_k == S + L + 1));
            chk("cyc_sel",   32'(rsp_sel),   32'(m_sel));
            chk("cyc_err",   32'(rsp_err),   32'(m_err));
            chk("cyc_ma",    32'(MA),        32'(m_ma));
            chk("cyc_rw",    32'(RW),        32'(m_rw));
            chk("cyc_dout",  32'(DOUT),      32'(m_dout));
            chk("cyc_bk4",   32'(BK4),       32'(m_bk4));
            chk("cyc_woco",  32'(WOCO),      32'(m_woco));
        end
    end

    // Called at a negedge while idle; returns at the negedge of the idle cycle after RECOVER
    task automatic do_txn(input string name, input logic we, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [4:0] exp_sel,
                          input logic exp_err, input logic noise);
        int n;
        int as_low;
        chk({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        as_low = 0;
        while (n <= 20) begin
            if (rsp_valid) break;
            if (!AS) as_low++;
            if (noise && n >= 2 && n <= 4) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hFFFF; req_wdata = 8'hFF;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(S + L + 1));
        chk({name, "_aslow"}, 32'(as_low), 32'(L));
        chk({name, "_sel"}, 32'(rsp_sel), 32'(exp_sel));
        chk({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        $display("txn %s we=%0d addr=%h wdata=%h sel=%b err=%0d latency=%0d", name, we, addr, wdata, rsp_sel, rsp_err, n);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_as",    32'(AS),        32'd1);
        chk("rst_ma",    32'(MA),        32'd0);
        chk("rst_rw",    32'(RW),        32'd1);
        chk("rst_dout",  32'(DOUT),      32'd0);
        chk("rst_bk4",   32'(BK4),       32'd0);
        chk("rst_woco",  32'(WOCO),      32'd0);
        chk("rst_rv",    32'(rsp_valid), 32'd0);
        chk("rst_sel",   32'(rsp_sel),   32'd0);
        chk("rst_err",   32'(rsp_err),   32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn("rd8000",      1'b0, 16'h8000, 8'h00, 5'b10000, 1'b0, 1'b0);
        do_txn("rd2000_bk0",  1'b0, 16'h2000, 8'h00, 5'b01000, 1'b0, 1'b0);
        do_txn("wr_ctrl_10",  1'b1, CTRL,     8'h10, 5'b00011, 1'b0, 1'b0);
        chk("bk4_after_wr10",  32'(BK4),  32'd1);
        chk("woco_after_wr10", 32'(WOCO), 32'd0);
        do_txn("rd2000_bk1",  1'b0, 16'h2000, 8'h00, 5'b10000, 1'b0, 1'b0);
        do_txn("rd0100_wo0",  1'b0, 16'h0100, 8'h00, 5'b00100, 1'b0, 1'b0);
        do_txn("wr_ctrl_20",  1'b1, CTRL,     8'h20, 5'b00011, 1'b0, 1'b0);
        chk("bk4_after_wr20",  32'(BK4),  32'd0);
        chk("woco_after_wr20", 32'(WOCO), 32'd1);
        do_txn("rd0100_wo1",  1'b0, 16'h0100, 8'h00, 5'b00001, 1'b0, 1'b0);
        do_txn("rd5C00",      1'b0, 16'h5C00, 8'h00, 5'b00011, 1'b0, 1'b0);
        do_txn("rd4000",      1'b0, 16'h4000, 8'h00, 5'b00001, 1'b0, 1'b0);
        do_txn("wr_plain",    1'b1, 16'h1234, 8'hA5, 5'b00001, 1'b0, 1'b1);
        chk("dout_hold", 32'(DOUT), 32'hA5);
        chk("rw_hold",   32'(RW),   32'd0);

        force_d19 = 1'b1;
        do_txn("rd8000_d19",  1'b0, 16'h8000, 8'h00, 5'b10000, SELCHK, 1'b0);
        force_d19 = 1'b0;
        do_txn("rd8000_ok",   1'b0, 16'h8000, 8'h00, 5'b10000, 1'b0, 1'b0);

        // Reset in the second strobe cycle of a read
        do_txn("wr_ctrl_30",  1'b1, CTRL,     8'h30, 5'b00011, 1'b0, 1'b0);
        chk("bk4_before_rst",  32'(BK4),  32'd1);
        chk("woco_before_rst", 32'(WOCO), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h8000; req_wdata = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_as", 32'(AS), 32'd1);
        chk("rst_mid_rv", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_mid_bk4",  32'(BK4),  32'd0);
        chk("rst_mid_woco", 32'(WOCO), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rel_ready", 32'(req_ready), 32'd1);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid) pulses++;
            end
            chk("rst_no_rsp", 32'(pulses), 32'd0);
        end
        do_txn("rd2000_post", 1'b0, 16'h2000, 8'h00, 5'b01000, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
